// File: rtl/crossbar_pkg.sv
// Shared types and constants for the crossbar read-side drain logic.
package crossbar_pkg;

  localparam int DATA_SIZE = 32;

  typedef logic [DATA_SIZE-1:0] data_t;

  // Buffered-beat count encoding of the 2-entry output buffer
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/fifo_rd_drain_skid_buf2.sv
// Two-entry valid/ready buffer: head register drives the output, skid register
// absorbs one extra beat while the head is stalled.
module skid_buf2 #(
  parameter int W = crossbar_pkg::DATA_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         flush,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);
  import crossbar_pkg::*;

  logic [1:0]   occ_q, occ_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         acc;

  // Valid/ready contract: a beat transfers on any edge where out_valid & out_ready.
  // out_valid depends only on registered state; out_ready never feeds back into push.
  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = head_q;
  assign occ       = occ_q;
  assign acc       = out_valid & out_ready;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push) begin
            head_d = push_data;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (acc && push) begin
            head_d = push_data;
          end else if (acc) begin
            occ_d = OCC_EMPTY;
          end else if (push) begin
            skid_d = push_data;
            occ_d  = OCC_TWO;
          end
        end
        OCC_TWO: begin
          // Caller never pushes when full, so only the drain case matters here
          if (acc) begin
            head_d = skid_q;
            occ_d  = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain of the async CDC FIFO: pops show-ahead entries into a 2-entry
// registered stream buffer and counts delivered beats.
module fifo_rd_drain #(
  parameter int DATA_SIZE = crossbar_pkg::DATA_SIZE,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rempty,
  input  logic [DATA_SIZE-1:0] rdata,
  output logic                 rpop,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic [1:0]           occ,
  output logic [CNT_W-1:0]     beat_cnt
);
  import crossbar_pkg::*;

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             acc;

  // Pop decision uses only registered occupancy, so downstream ready never reaches rpop
  assign rpop = rst & ~rempty & (occ != OCC_TWO) & ~flush;
  assign acc  = out_valid & out_ready;

  skid_buf2 #(
    .W(DATA_SIZE)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (rpop),
    .push_data(rdata),
    .flush    (flush),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .occ      (occ)
  );

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (acc) beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) beat_cnt_q <= '0;
    else      beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: FIFO model on the read port, scoreboard on the output stream.
module tb_fifo_rd_drain;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         rempty;
  logic [W-1:0] rdata;
  logic         out_ready;
  logic         flush;
  logic         rpop, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occ;
  logic [15:0]  beat_cnt;
  logic         rpop_w4, out_valid_w4;
  logic [W-1:0] out_data_w4;
  logic [1:0]   occ_w4;
  logic [3:0]   beat_cnt_w4;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] bp_vals[3];
  logic         gap = 1'b0;
  logic         do_pop = 1'b0;
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc;

  fifo_rd_drain #(.DATA_SIZE(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rempty(rempty), .rdata(rdata), .rpop(rpop),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush(flush), .occ(occ), .beat_cnt(beat_cnt)
  );

  fifo_rd_drain #(.DATA_SIZE(W), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .rempty(rempty), .rdata(rdata), .rpop(rpop_w4),
    .out_valid(out_valid_w4), .out_data(out_data_w4), .out_ready(out_ready),
    .flush(flush), .occ(occ_w4), .beat_cnt(beat_cnt_w4)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO read-port model (show-ahead)
  task automatic refresh();
    rempty = gap || (fifo_q.size() == 0);
    rdata  = rempty ? 'x : fifo_q[0];
  endtask

  task automatic fifo_push(input logic [W-1:0] v, input logic to_exp);
    fifo_q.push_back(v);
    if (to_exp) exp_q.push_back(v);
    refresh();
  endtask

  always @(posedge clk) begin
    #1;
    if (do_pop && fifo_q.size() != 0) fifo_q.delete(0);
    do_pop = 1'b0;
    refresh();
  end

  // Monitor: samples mid-low-phase, after inputs settle and before the next edge
  always @(negedge clk) begin
    #2;
    do_pop = rpop;
    if (rst) begin
      chk("rpop_rule", 32'(rpop && (rempty || occ == 2'd2)), 32'd0);
      chk("rpop_rule_w4", 32'(rpop_w4 && (rempty || occ_w4 == 2'd2)), 32'd0);
      chk("occ_range", 32'(occ > 2'd2), 32'd0);
      chk("valid_occ", 32'(out_valid), 32'(occ != 2'd0));
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid_w4 && out_ready && exp_q.size() != 0)
        chk("w4_beat_data", out_data_w4, exp_q[0]);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL beat_extra: got 0x%0h expected no beat", out_data);
        end else begin
          chk("beat_data", out_data, exp_q.pop_front());
        end
      end
    end
    prev_hold = rst && out_valid && !out_ready && !flush;
    prev_data = out_data;
  end

  initial begin
    rst = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    refresh();
    bp_vals[0] = 32'hA;
    bp_vals[1] = 32'hB;
    bp_vals[2] = 32'hC;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_rpop", 32'(rpop), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Streaming 0x11..0x18 with out_ready=1
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) fifo_push(32'(8'h11 + i), 1'b1);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stream_rpop", 32'(rpop), 32'(i < 8));
      chk("stream_valid", 32'(out_valid), 32'(i >= 1 && i <= 8));
      @(negedge clk);
    end
    #1;
    chk("stream_cnt", 32'(beat_cnt), 32'd8);

    // Back-pressure with 0xA,0xB,0xC
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) fifo_push(bp_vals[i], 1'b1);
    repeat (4) @(negedge clk);
    #1;
    chk("bp_occ", 32'(occ), 32'd2);
    chk("bp_rpop", 32'(rpop), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_data", out_data, 32'hA);
    chk("bp_rempty", 32'(rempty), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_drain_valid", 32'(out_valid), 32'd1);
      chk("bp_drain_data", out_data, bp_vals[i]);
      @(negedge clk);
    end
    #1;
    chk("bp_done_valid", 32'(out_valid), 32'd0);
    chk("bp_cnt", 32'(beat_cnt), 32'd11);

    // Flush with occ=2 (0x5,0x6); 0x5 accepted in the flush cycle, 0x6 dropped, 0x7 follows
    @(negedge clk);
    out_ready = 1'b0;
    fifo_push(32'h5, 1'b1);
    fifo_push(32'h6, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("fl_pre_occ", 32'(occ), 32'd2);
    @(negedge clk);
    fifo_push(32'h7, 1'b1);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("fl_rpop", 32'(rpop), 32'd0);
    chk("fl_head", out_data, 32'h5);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_occ", 32'(occ), 32'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_cnt", 32'(beat_cnt), 32'd12);
    chk("fl_rpop_after", 32'(rpop), 32'd1);
    @(negedge clk);
    #1;
    chk("fl_next_valid", 32'(out_valid), 32'd1);
    chk("fl_next_data", out_data, 32'h7);
    @(negedge clk);
    #1;
    chk("fl_next_cnt", 32'(beat_cnt), 32'd13);

    // Async reset mid-stream with occ=2
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) fifo_push(32'(8'h21 + i), 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("mr_pre_occ", 32'(occ), 32'd2);
    @(negedge clk);
    rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    refresh();
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_occ", 32'(occ), 32'd0);
    chk("mr_cnt", 32'(beat_cnt), 32'd0);
    chk("mr_cnt_w4", 32'(beat_cnt_w4), 32'd0);
    chk("mr_rpop", 32'(rpop), 32'd0);
    chk("mr_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Counter wrap: 17 beats into a 4-bit counter
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) fifo_push(32'(12'h100 + i), 1'b1);
    repeat (20) @(negedge clk);
    #1;
    chk("wrap_cnt_w4", 32'(beat_cnt_w4), 32'd1);
    chk("wrap_cnt", 32'(beat_cnt), 32'd17);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Random gaps and back-pressure, 10000 beats
    @(negedge clk);
    for (int i = 0; i < 10000; i++) fifo_push($urandom, 1'b1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      gap = ($urandom_range(0, 3) == 0);
      refresh();
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    gap = 1'b0;
    refresh();
    #1;
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_cnt", 32'(beat_cnt), 32'd10017);
    chk("rand_cnt_w4", 32'(beat_cnt_w4), 32'd1);
    chk("rand_occ", 32'(occ), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
